// File: rtl/bcd_updown_counter.sv
// N-digit BCD up/down counter with manual digit adjust, wrap or saturate
// terminal behaviour and a STOP/RUN/ADJ/DONE control state machine.
module bcd_updown_counter #(
    parameter int NUM_DIGITS = 4,
    parameter int WRAP       = 1,
    parameter int SEL_W      = 2
) (
    input  logic                    clk_used,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    tick,
    input  logic                    run,
    input  logic                    dir,
    input  logic                    adj,
    input  logic [SEL_W-1:0]        adj_sel,
    input  logic                    adj_inc,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [1:0]              state,
    output logic                    wrap_pulse,
    output logic                    is_zero,
    output logic                    is_max
);

    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_ADJ  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    localparam bit SATURATE = (WRAP == 0);

    state_t                  state_reg, state_next;
    logic [4*NUM_DIGITS-1:0] digits_reg, digits_next;
    logic                    wrap_reg, wrap_next;

    logic [4*NUM_DIGITS-1:0] count_vec;
    logic [4*NUM_DIGITS-1:0] adj_vec;
    logic [NUM_DIGITS-1:0]   is9, is0;
    // low9[k] / low0[k]: every digit below k is 9 / 0 (the ripple carry / borrow)
    logic [NUM_DIGITS:0]     low9, low0;
    logic                    terminal;

    assign low9[0] = 1'b1;
    assign low0[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] cur;
            logic [3:0] inc_val;
            logic [3:0] dec_val;

            assign cur          = digits_reg[4*gi +: 4];
            assign is9[gi]      = (cur == 4'd9);
            assign is0[gi]      = (cur == 4'd0);
            assign inc_val      = is9[gi] ? 4'd0 : cur + 4'd1;
            assign dec_val      = is0[gi] ? 4'd9 : cur - 4'd1;
            assign low9[gi+1]   = low9[gi] & is9[gi];
            assign low0[gi+1]   = low0[gi] & is0[gi];

            assign count_vec[4*gi +: 4] = dir ? (low9[gi] ? inc_val : cur)
                                              : (low0[gi] ? dec_val : cur);
            // Out-of-range adj_sel matches no digit, so the pulse is dropped.
            assign adj_vec[4*gi +: 4]   = (adj_inc && (adj_sel == SEL_W'(gi))) ? inc_val : cur;
        end
    endgenerate

    assign terminal = dir ? low9[NUM_DIGITS] : low0[NUM_DIGITS];

    always_comb begin
        state_next  = state_reg;
        digits_next = digits_reg;
        wrap_next   = 1'b0;

        if (clear) begin
            state_next  = ST_STOP;
            digits_next = '0;
        end else begin
            case (state_reg)
                ST_STOP: begin
                    if (adj)
                        state_next = ST_ADJ;
                    else if (run)
                        state_next = ST_RUN;
                end
                ST_RUN: begin
                    if (adj)
                        state_next = ST_ADJ;
                    else if (!run)
                        state_next = ST_STOP;
                    else if (tick) begin
                        if (terminal && SATURATE)
                            state_next = ST_DONE;
                        else begin
                            digits_next = count_vec;
                            wrap_next   = terminal;
                        end
                    end
                end
                ST_ADJ: begin
                    digits_next = adj_vec;
                    if (!adj)
                        state_next = run ? ST_RUN : ST_STOP;
                end
                ST_DONE: begin
                    // Only leaving via STOP lets counting resume, whatever dir does.
                    if (adj)
                        state_next = ST_ADJ;
                    else if (!run)
                        state_next = ST_STOP;
                end
                default: state_next = ST_STOP;
            endcase
        end
    end

    always_ff @(posedge clk_used) begin
        if (rst) begin
            state_reg  <= ST_STOP;
            digits_reg <= '0;
            wrap_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            digits_reg <= digits_next;
            wrap_reg   <= wrap_next;
        end
    end

    assign digits     = digits_reg;
    assign state      = state_reg;
    assign wrap_pulse = wrap_reg;
    assign is_zero    = low0[NUM_DIGITS];
    assign is_max     = low9[NUM_DIGITS];

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: a 6-digit wrapping counter (A) and a 3-digit saturating
// counter (B) share stimulus; expectations are queued and checked by a monitor.
module tb_bcd_updown_counter;

    localparam logic [1:0] S_STOP = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_ADJ  = 2'b10;
    localparam logic [1:0] S_DONE = 2'b11;

    logic clk_used = 1'b0;
    always #5 clk_used = ~clk_used;

    logic       rst, clear, tick, run, dir, adj, adj_inc;
    logic [2:0] adj_sel;

    logic [23:0] digits_a;
    logic [1:0]  state_a;
    logic        wrap_a, zero_a, max_a;
    logic [11:0] digits_b;
    logic [1:0]  state_b;
    logic        wrap_b, zero_b, max_b;

    bcd_updown_counter #(.NUM_DIGITS(6), .WRAP(1), .SEL_W(3)) dut_a (
        .clk_used(clk_used), .rst(rst), .clear(clear), .tick(tick), .run(run),
        .dir(dir), .adj(adj), .adj_sel(adj_sel), .adj_inc(adj_inc),
        .digits(digits_a), .state(state_a), .wrap_pulse(wrap_a),
        .is_zero(zero_a), .is_max(max_a)
    );

    bcd_updown_counter #(.NUM_DIGITS(3), .WRAP(0), .SEL_W(2)) dut_b (
        .clk_used(clk_used), .rst(rst), .clear(clear), .tick(tick), .run(run),
        .dir(dir), .adj(adj), .adj_sel(adj_sel[1:0]), .adj_inc(adj_inc),
        .digits(digits_b), .state(state_b), .wrap_pulse(wrap_b),
        .is_zero(zero_b), .is_max(max_b)
    );

    typedef struct {
        int          cyc;
        bit          on_b;
        logic [23:0] digits;
        logic [1:0]  state;
        logic        wrap;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   cycle_cnt = 0;
    int   checks    = 0;
    int   errors    = 0;

    always @(posedge clk_used) cycle_cnt <= cycle_cnt + 1;

    // Monitor: outputs only move on posedge, so the negedge view is stable.
    exp_t        mon_e;
    logic [23:0] got_d;
    logic [1:0]  got_s;
    logic        got_w, got_z, got_m, exp_z, exp_m;
    always @(negedge clk_used) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cycle_cnt) begin
            mon_e = sb_q.pop_front();
            if (mon_e.on_b) begin
                got_d = {12'h000, digits_b}; got_s = state_b;
                got_w = wrap_b; got_z = zero_b; got_m = max_b;
                exp_m = (mon_e.digits == 24'h000999);
            end else begin
                got_d = digits_a; got_s = state_a;
                got_w = wrap_a; got_z = zero_a; got_m = max_a;
                exp_m = (mon_e.digits == 24'h999999);
            end
            exp_z = (mon_e.digits == 24'h0);
            checks++;
            if (mon_e.cyc != cycle_cnt || got_d !== mon_e.digits || got_s !== mon_e.state ||
                got_w !== mon_e.wrap || got_z !== exp_z || got_m !== exp_m) begin
                errors++;
                $display("FAIL %s (%s): got digits=%h state=%0d wrap=%b zero=%b max=%b, expected digits=%h state=%0d wrap=%b zero=%b max=%b",
                         mon_e.name, mon_e.on_b ? "B" : "A", got_d, got_s, got_w, got_z, got_m,
                         mon_e.digits, mon_e.state, mon_e.wrap, exp_z, exp_m);
            end else begin
                $display("ok   %s (%s): digits=%h state=%0d wrap=%b", mon_e.name,
                         mon_e.on_b ? "B" : "A", got_d, got_s, got_w);
            end
        end
    end

    // Expectation for the outputs seen after the next rising edge.
    task automatic expect_out(input bit on_b, input string name, input logic [23:0] d,
                              input logic [1:0] st, input logic w);
        exp_t e;
        e.cyc = cycle_cnt + 1; e.on_b = on_b; e.digits = d;
        e.state = st; e.wrap = w; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk_used);
    endtask

    function automatic logic [23:0] to_bcd(input int v);
        logic [23:0] r;
        int          t;
        t = v;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    logic [11:0] model_b;

    task automatic adj_pulses_b(input int sel, input int n);
        logic [3:0] dg;
        for (int i = 0; i < n; i++) begin
            adj_sel = 3'(sel);
            adj_inc = 1'b1;
            if (sel < 3) begin
                dg = model_b[4*sel +: 4];
                dg = (dg == 4'd9) ? 4'd0 : dg + 4'd1;
                model_b[4*sel +: 4] = dg;
            end
            expect_out(1'b1, $sformatf("adj_sel%0d", sel), {12'h000, model_b}, S_ADJ, 1'b0);
            step();
        end
        adj_inc = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; tick = 1'b0; run = 1'b0; dir = 1'b0;
        adj = 1'b0; adj_inc = 1'b0; adj_sel = 3'd0;
        expect_out(1'b0, "reset", 24'h0, S_STOP, 1'b0);
        expect_out(1'b1, "reset", 24'h0, S_STOP, 1'b0);
        step();

        // Up count on A; tick on the STOP->RUN edge must be ignored.
        rst = 1'b0; run = 1'b1; dir = 1'b1; tick = 1'b1;
        expect_out(1'b0, "start_tick_ignored", 24'h0, S_RUN, 1'b0);
        step();
        for (int i = 1; i <= 12; i++) begin
            expect_out(1'b0, $sformatf("up_tick%0d", i), to_bcd(i), S_RUN, 1'b0);
            step();
        end
        tick = 1'b0;
        expect_out(1'b0, "no_tick_hold", 24'h000012, S_RUN, 1'b0);
        step();

        // Wrap both ways on A.
        clear = 1'b1;
        expect_out(1'b0, "clear", 24'h0, S_STOP, 1'b0);
        step();
        clear = 1'b0;
        expect_out(1'b0, "rerun", 24'h0, S_RUN, 1'b0);
        step();
        dir = 1'b0; tick = 1'b1;
        expect_out(1'b0, "down_wrap", 24'h999999, S_RUN, 1'b1);
        step();
        tick = 1'b0;
        expect_out(1'b0, "wrap_one_cycle", 24'h999999, S_RUN, 1'b0);
        step();
        dir = 1'b1; tick = 1'b1;
        expect_out(1'b0, "up_wrap", 24'h000000, S_RUN, 1'b1);
        step();
        expect_out(1'b0, "after_wrap", 24'h000001, S_RUN, 1'b0);
        step();

        // Adjust on A, then a long down borrow.
        tick = 1'b0; clear = 1'b1;
        expect_out(1'b0, "clear2", 24'h0, S_STOP, 1'b0);
        step();
        clear = 1'b0; adj = 1'b1; adj_inc = 1'b1; adj_sel = 3'd5; tick = 1'b1;
        expect_out(1'b0, "adj_enter_inc_ignored", 24'h0, S_ADJ, 1'b0);
        step();
        expect_out(1'b0, "adj_digit5", 24'h100000, S_ADJ, 1'b0);
        step();
        adj_sel = 3'd6;
        expect_out(1'b0, "adj_sel6_ignored", 24'h100000, S_ADJ, 1'b0);
        step();
        adj_sel = 3'd7;
        expect_out(1'b0, "adj_sel7_ignored", 24'h100000, S_ADJ, 1'b0);
        step();
        adj = 1'b0; adj_inc = 1'b0;
        expect_out(1'b0, "adj_exit_run", 24'h100000, S_RUN, 1'b0);
        step();
        dir = 1'b0;
        expect_out(1'b0, "down_borrow", 24'h099999, S_RUN, 1'b0);
        step();
        clear = 1'b1;
        expect_out(1'b0, "clear_beats_tick", 24'h0, S_STOP, 1'b0);
        step();
        clear = 1'b0; dir = 1'b1; tick = 1'b0;
        expect_out(1'b0, "rerun2", 24'h0, S_RUN, 1'b0);
        step();
        tick = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            expect_out(1'b0, $sformatf("count%0d", i), to_bcd(i), S_RUN, 1'b0);
            step();
        end
        rst = 1'b1;
        expect_out(1'b0, "rst_mid_count", 24'h0, S_STOP, 1'b0);
        expect_out(1'b1, "rst_mid_count", 24'h0, S_STOP, 1'b0);
        step();

        // Saturating counter B.
        rst = 1'b0; run = 1'b1; dir = 1'b0; tick = 1'b0;
        expect_out(1'b1, "b_run", 24'h0, S_RUN, 1'b0);
        step();
        tick = 1'b1;
        expect_out(1'b1, "b_down_sat_done", 24'h0, S_DONE, 1'b0);
        step();
        dir = 1'b1;
        expect_out(1'b1, "b_done_dir_flip", 24'h0, S_DONE, 1'b0);
        step();
        run = 1'b0; tick = 1'b0;
        expect_out(1'b1, "b_done_stop", 24'h0, S_STOP, 1'b0);
        step();
        run = 1'b1;
        expect_out(1'b1, "b_rerun", 24'h0, S_RUN, 1'b0);
        step();
        tick = 1'b1;
        expect_out(1'b1, "b_resume", 24'h001, S_RUN, 1'b0);
        step();
        tick = 1'b0; clear = 1'b1;
        expect_out(1'b1, "b_clear", 24'h0, S_STOP, 1'b0);
        step();
        clear = 1'b0; adj = 1'b1; run = 1'b0;
        expect_out(1'b1, "b_adj_enter", 24'h0, S_ADJ, 1'b0);
        step();
        model_b = 12'h000;
        adj_pulses_b(2, 11);
        adj_pulses_b(3, 1);
        adj_pulses_b(2, 8);
        adj_pulses_b(1, 9);
        adj_pulses_b(0, 9);
        adj = 1'b0; run = 1'b1; dir = 1'b1;
        expect_out(1'b1, "b_adj_exit", 24'h999, S_RUN, 1'b0);
        step();
        tick = 1'b1;
        expect_out(1'b1, "b_up_sat_done", 24'h999, S_DONE, 1'b0);
        step();
        tick = 1'b0; adj = 1'b1;
        expect_out(1'b1, "b_done_to_adj", 24'h999, S_ADJ, 1'b0);
        step();
        clear = 1'b1;
        expect_out(1'b1, "b_clear_in_adj", 24'h0, S_STOP, 1'b0);
        step();
        clear = 1'b0; adj = 1'b0; run = 1'b0;
        step();
        step();

        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
Parametrised N-digit BCD up/down counter for the stopwatch/timer datapath; the successor to the fixed 4-digit forward-only counter. Adds count direction, digit-wise manual adjust, wrap or saturate terminal behaviour, a run/adjust/done state machine and terminal-event flags. It sits between the tick divider and the display mux.

Parameters:
NUM_DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
WRAP, 1, 1 = wrap at terminal count; 0 = saturate and enter DONE.
SEL_W, 2, width of adj_sel; must satisfy 2**SEL_W >= NUM_DIGITS.

Ports:
clk_used  in  1  system clock; all state changes on its rising edge
rst  in  1  synchronous, active-high reset
clear  in  1  synchronous clear of all digits (lower priority than rst)
tick  in  1  one-cycle count-enable pulse from the divider
run  in  1  level; 1 = counting requested
dir  in  1  level; 1 = count up, 0 = count down
adj  in  1  level; 1 = adjust mode, counting suspended
adj_sel  in  SEL_W  digit index to adjust
adj_inc  in  1  one-cycle pulse; increments the selected digit
digits  out  4*NUM_DIGITS  registered BCD value; digit k at bits [4k+3:4k]
state  out  2  00 STOP, 01 RUN, 10 ADJ, 11 DONE
wrap_pulse  out  1  registered; high for one cycle when the count wraps
is_zero  out  1  all digits == 0 (decoded from registered digits)
is_max  out  1  all digits == 9 (decoded from registered digits)

Behaviour:
- Reset (rst=1): digits=0, state=STOP, wrap_pulse=0. rst overrides every other input.
- Priority, highest first: rst > clear > adj > run/tick.
- clear=1: digits <= 0, state <= STOP, wrap_pulse <= 0. It is honoured in every state, including ADJ.
- Next-state logic is evaluated from the current state and inputs each cycle:
  STOP: adj -> ADJ; else run -> RUN.
  RUN: adj -> ADJ; else !run -> STOP.
  ADJ: !adj -> (run ? RUN : STOP).
  DONE: adj -> ADJ; else !run -> STOP; otherwise it stays in DONE. DONE is only reachable when WRAP=0.
- Count condition: current state==RUN, run=1, adj=0, clear=0 and tick=1. Digits update in the same edge, so latency is 1 clock from tick.
- A tick in the cycle where STOP->RUN is taken is ignored.
- Up count: ripple BCD increment. Digit k increments iff all lower digits == 9; digits that were 9 go to 0.
- Down count: ripple BCD decrement. Digit k decrements iff all lower digits == 0; digits that were 0 go to 9.
- Terminal, WRAP=1:
  Up from all-9 gives all-0, with wrap_pulse=1 for that one cycle.
  Down from all-0 gives all-9, with wrap_pulse=1.
  The state remains RUN.
- Terminal, WRAP=0:
  A counting tick at all-9 (up) or all-0 (down) leaves digits unchanged and sets state <= DONE. wrap_pulse stays 0.
  Reversing dir while in DONE does not resume counting; run must drop first (DONE -> STOP).
- wrap_pulse is 0 in every cycle without a wrap event.
- Adjust: in state ADJ, an adj_inc pulse increments digit[adj_sel] modulo 10 (9 -> 0). There is no carry into neighbouring digits.
  adj_sel >= NUM_DIGITS: adj_inc is ignored.
  adj_inc outside ADJ, including the cycle in which ADJ is entered, is ignored. tick is ignored in ADJ.
- Direction may change on any cycle; it takes effect on the next counting tick.
- Digit values are always 0..9; there is no load path, so illegal BCD is unreachable.
- is_zero/is_max: combinational from the digit registers, so they change in the cycle after the update edge.

Test Plan:
1. Reset, run=1, dir=1, 12 ticks -> digits=0x0012, state=RUN; the 10th tick takes 0x0009 to 0x0010.
2. WRAP=1, digits=0x9999, up tick -> 0x0000, wrap_pulse high for exactly 1 cycle; one further down tick -> 0x9999 with wrap_pulse high again.
3. WRAP=0, digits=0x0000, dir=0, tick -> digits stay 0x0000, state=DONE; set dir=1 and tick -> no change; drop run -> STOP; raise run and tick -> 0x0001.
4. adj=1, adj_sel=2, 11 adj_inc pulses starting from 0x0000 -> 0x0100 (digit 2 wraps 9 -> 0 -> 1, digit 3 unchanged); adj_sel=3 with NUM_DIGITS=3 -> ignored.
5. Simultaneous clear=1 and tick=1 in RUN at 0x0457 -> 0x0000, state=STOP; assert rst mid-count at 0x0123 -> 0x0000 next edge, STOP.
6. NUM_DIGITS=6, dir=0, start 0x100000, 1 tick -> 0x099999, is_zero=0, is_max=0.
